// File: rtl/nes_controller_reader.sv
// NES controller poller: latches the pad, clocks out 8 serial bits and presents them as registered buttons.
// Optional NES_PRESS_EDGE_EN adds one-cycle a_press/b_press rising-edge strobes.
`timescale 1ns/1ps
module nes_controller_reader #(
    parameter int HALF_PERIOD = 300,
    parameter int POLL_PERIOD = 833333
) (
    input  logic clk,
    input  logic start,
    input  logic nes_data,
    output logic nes_latch,
    output logic nes_pulse,
    output logic a,
    output logic b,
    output logic select_btn,
    output logic start_btn,
    output logic up,
    output logic down,
    output logic left,
    output logic right,
    output logic valid
`ifdef NES_PRESS_EDGE_EN
    ,
    output logic a_press,
    output logic b_press
`endif
);

    localparam int CNT_W  = $clog2(4 * HALF_PERIOD + 1);
    localparam int POLL_W = $clog2(POLL_PERIOD);

    localparam logic [CNT_W-1:0]  HP_LAST    = CNT_W'(HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  LATCH_LAST = CNT_W'(2 * HALF_PERIOD - 1);
    localparam logic [CNT_W-1:0]  TAIL_LAST  = CNT_W'(4 * HALF_PERIOD);
    localparam logic [POLL_W-1:0] POLL_LAST  = POLL_W'(POLL_PERIOD - 1);

    typedef enum logic [2:0] {
        IDLE,
        LATCH,
        WAIT0,
        PULSE_HI,
        PULSE_LO,
        DONE
    } state_t;

    state_t            state;
    logic              sync_p0;
    logic              sync_p1;
    logic              sample_bit;
    logic              poll_tick;
    logic [POLL_W-1:0] poll_cnt;
    logic [CNT_W-1:0]  phase_cnt;
    logic [2:0]        bit_idx;
    logic [7:0]        shift_reg;
`ifdef NES_PRESS_EDGE_EN
    logic              a_prev;
    logic              b_prev;
`endif

    // Opposing directions pressed together cancel each other out.
    function automatic logic socd_keep(input logic self_dir, input logic opp_dir);
        return self_dir & ~opp_dir;
    endfunction

    assign sample_bit = ~sync_p1;
    assign poll_tick  = (poll_cnt == POLL_LAST);

    always_ff @(posedge clk) begin
        if (start) begin
            state      <= IDLE;
            sync_p0    <= 1'b1;
            sync_p1    <= 1'b1;
            poll_cnt   <= '0;
            phase_cnt  <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            nes_latch  <= 1'b0;
            nes_pulse  <= 1'b0;
            a          <= 1'b0;
            b          <= 1'b0;
            select_btn <= 1'b0;
            start_btn  <= 1'b0;
            up         <= 1'b0;
            down       <= 1'b0;
            left       <= 1'b0;
            right      <= 1'b0;
            valid      <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            a_press    <= 1'b0;
            b_press    <= 1'b0;
            a_prev     <= 1'b0;
            b_prev     <= 1'b0;
`endif
        end else begin
            sync_p0  <= nes_data;
            sync_p1  <= sync_p0;
            poll_cnt <= poll_tick ? '0 : poll_cnt + POLL_W'(1);
            valid    <= 1'b0;
`ifdef NES_PRESS_EDGE_EN
            a_press  <= 1'b0;
            b_press  <= 1'b0;
`endif
            case (state)
                IDLE: begin
                    if (poll_tick) begin
                        state     <= LATCH;
                        phase_cnt <= '0;
                        nes_latch <= 1'b1;
                    end
                end
                LATCH: begin
                    if (phase_cnt == LATCH_LAST) begin
                        state     <= WAIT0;
                        phase_cnt <= '0;
                        nes_latch <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                WAIT0: begin
                    if (phase_cnt == HP_LAST) begin
                        shift_reg <= {sample_bit, shift_reg[7:1]};
                        state     <= PULSE_HI;
                        phase_cnt <= '0;
                        bit_idx   <= 3'd1;
                        nes_pulse <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                PULSE_HI: begin
                    if (phase_cnt == HP_LAST) begin
                        state     <= PULSE_LO;
                        phase_cnt <= '0;
                        nes_pulse <= 1'b0;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                PULSE_LO: begin
                    if (phase_cnt == HP_LAST) begin
                        shift_reg <= {sample_bit, shift_reg[7:1]};
                    end
                    // After bit 7 the line idles low for a tail so the read lasts 20 half periods.
                    if (bit_idx == 3'd7) begin
                        if (phase_cnt == TAIL_LAST) begin
                            state      <= DONE;
                            phase_cnt  <= '0;
                            valid      <= 1'b1;
                            a          <= shift_reg[0];
                            b          <= shift_reg[1];
                            select_btn <= shift_reg[2];
                            start_btn  <= shift_reg[3];
                            up         <= socd_keep(shift_reg[4], shift_reg[5]);
                            down       <= socd_keep(shift_reg[5], shift_reg[4]);
                            left       <= socd_keep(shift_reg[6], shift_reg[7]);
                            right      <= socd_keep(shift_reg[7], shift_reg[6]);
`ifdef NES_PRESS_EDGE_EN
                            a_press    <= shift_reg[0] & ~a_prev;
                            b_press    <= shift_reg[1] & ~b_prev;
                            a_prev     <= shift_reg[0];
                            b_prev     <= shift_reg[1];
`endif
                        end else begin
                            phase_cnt <= phase_cnt + CNT_W'(1);
                        end
                    end else if (phase_cnt == HP_LAST) begin
                        state     <= PULSE_HI;
                        phase_cnt <= '0;
                        bit_idx   <= bit_idx + 3'd1;
                        nes_pulse <= 1'b1;
                    end else begin
                        phase_cnt <= phase_cnt + CNT_W'(1);
                    end
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state     <= IDLE;
                    nes_latch <= 1'b0;
                    nes_pulse <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_nes_controller_reader.sv
// Randomized bench for nes_controller_reader: timeline-based reference model plus directed literal checks.
`timescale 1ns/1ps
module tb_nes_controller_reader;
    localparam int HP  = 4;
    localparam int PP  = 100;
    localparam int LAT = 20 * HP + 1;

    logic clk = 1'b0;
    logic start = 1'b1;
    logic nes_data = 1'b1;
    logic nes_latch, nes_pulse, valid;
    logic a, b, select_btn, start_btn, up, down, left, right;
    logic [7:0] btn;
`ifdef NES_PRESS_EDGE_EN
    logic a_press, b_press;
`endif

    always #5 clk = ~clk;

    nes_controller_reader #(.HALF_PERIOD(HP), .POLL_PERIOD(PP)) dut (
        .clk(clk), .start(start), .nes_data(nes_data),
        .nes_latch(nes_latch), .nes_pulse(nes_pulse),
        .a(a), .b(b), .select_btn(select_btn), .start_btn(start_btn),
        .up(up), .down(down), .left(left), .right(right),
        .valid(valid)
`ifdef NES_PRESS_EDGE_EN
        , .a_press(a_press), .b_press(b_press)
`endif
    );

    assign btn = {right, left, down, up, start_btn, select_btn, b, a};

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Controller stand-in: loads on latch, shifts on each pulse rising edge, active-low data.
    typedef enum int {M_DISC, M_CTRL, M_NOISE} mode_t;
    mode_t mode = M_DISC;
    logic [7:0] pattern = 8'h00;
    logic [7:0] pad_sh = 8'h00;
    logic prev_pulse = 1'b0;

    always @(negedge clk) begin
        if (mode == M_CTRL) begin
            if (nes_latch) pad_sh = pattern;
            else if (nes_pulse && !prev_pulse) pad_sh = pad_sh >> 1;
            nes_data = ~pad_sh[0];
        end else if (mode == M_NOISE) begin
            nes_data = 1'($urandom_range(0, 1));
        end else begin
            nes_data = 1'b1;
        end
        prev_pulse = nes_pulse;
    end

    // Reference model: tick every PP edges after reset when idle; outputs follow fixed offsets from the tick.
    logic hist [0:255];
    int   g = 0;
    int   since_rst = 0;
    int   tick_at = 0;
    bit   active = 0;
    bit   model_ok = 0;
    logic exp_latch = 0, exp_pulse = 0, exp_valid = 0;
    logic [7:0] exp_btn = 8'h00;
    logic exp_ap = 0, exp_bp = 0;

    always @(posedge clk) begin
        int d;
        bit idle;
        logic [7:0] raw;
        g++;
        hist[g % 256] = nes_data;
        if (start) begin
            since_rst = 0;
            active = 0;
            exp_latch = 0; exp_pulse = 0; exp_valid = 0;
            exp_btn = 8'h00; exp_ap = 0; exp_bp = 0;
            model_ok = 1;
        end else if (model_ok) begin
            since_rst++;
            idle = !active || ((g - 1 - tick_at) > LAT);
            if ((since_rst % PP) == 0 && idle) begin
                active = 1;
                tick_at = g;
            end
            d = g - tick_at;
            exp_latch = active && d < 2 * HP;
            exp_pulse = active && d >= 3 * HP && d < 17 * HP && (((d - 3 * HP) / HP) % 2 == 0);
            exp_valid = 0; exp_ap = 0; exp_bp = 0;
            if (active && d == LAT) begin
                for (int k = 0; k < 8; k++)
                    raw[k] = ~hist[(tick_at + 3 * HP + 2 * k * HP - 2) % 256];
                if (raw[6] && raw[7]) begin raw[6] = 0; raw[7] = 0; end
                if (raw[4] && raw[5]) begin raw[4] = 0; raw[5] = 0; end
                exp_ap = raw[0] & ~exp_btn[0];
                exp_bp = raw[1] & ~exp_btn[1];
                exp_btn = raw;
                exp_valid = 1;
            end
        end
    end

    always @(negedge clk) begin
        if (model_ok) begin
            chk("model_lines", int'({nes_latch, nes_pulse}), int'({exp_latch, exp_pulse}));
            chk("model_valid", int'(valid), int'(exp_valid));
            chk("model_buttons", int'(btn), int'(exp_btn));
`ifdef NES_PRESS_EDGE_EN
            chk("model_press", int'({a_press, b_press}), int'({exp_ap, exp_bp}));
`endif
        end
    end

    task automatic wait_valid(output bit ok);
        ok = 0;
        for (int i = 0; i < 150; i++) begin
            @(negedge clk);
            if (valid) begin
                ok = 1;
                break;
            end
        end
        if (!ok) chk("valid_timeout", 0, 1);
    endtask

    task automatic poll_pattern(input logic [7:0] p, input logic [7:0] exp, input string name);
        bit ok;
        pattern = p;
        mode = M_CTRL;
        wait_valid(ok);
        if (ok) chk(name, int'(btn), int'(exp));
    endtask

    initial begin
        bit ok;
        int n;
        int rises;
        int guard;
        logic pp;

        repeat (3) @(negedge clk);
        start = 1'b0;
        for (int t = 0; t <= 200; t++) begin
            @(negedge clk);
            if (t == 98 || t == 107) chk("latch_off", int'(nes_latch), 0);
            if (t == 99 || t == 106) chk("latch_on", int'(nes_latch), 1);
            if (t == 179) chk("valid_early", int'(valid), 0);
            if (t == 180) begin
                chk("first_valid", int'(valid), 1);
                chk("disc_buttons", int'(btn), 0);
            end
        end
        wait_valid(ok);

        poll_pattern(8'h81, 8'h81, "a_right");
        n = 0;
        repeat (100) begin
            @(negedge clk);
            if (valid) n++;
        end
        chk("valid_rate", n, 1);
        poll_pattern(8'hC0, 8'h00, "left_right_socd");
        poll_pattern(8'h40, 8'h40, "left_only");
        poll_pattern(8'h30, 8'h00, "up_down_socd");
        poll_pattern(8'h3C, 8'h0C, "sel_start_updown");
        mode = M_DISC;
        wait_valid(ok);
        if (ok) chk("disconnected", int'(btn), 0);
        poll_pattern(8'h81, 8'h81, "a_right_again");

        // Abort during the pulse-high of bit 3.
        rises = 0;
        guard = 0;
        pp = nes_pulse;
        while (rises < 3 && guard < 200) begin
            @(negedge clk);
            guard++;
            if (nes_pulse && !pp) rises++;
            pp = nes_pulse;
        end
        if (guard >= 200) chk("pulse_timeout", 0, 1);
        start = 1'b1;
        @(negedge clk);
        chk("abort_lines", int'({nes_latch, nes_pulse}), 0);
        chk("abort_valid", int'(valid), 0);
        chk("abort_buttons", int'(btn), 0);
        start = 1'b0;
        n = 0;
        for (int t = 0; t <= 180; t++) begin
            @(negedge clk);
            if (t < 180) n += int'(valid);
            if (t == 98) chk("post_abort_latch_off", int'(nes_latch), 0);
            if (t == 99) chk("post_abort_latch_on", int'(nes_latch), 1);
            if (t == 180) chk("post_abort_valid", int'(valid), 1);
        end
        chk("no_valid_after_abort", n, 0);

        for (int i = 0; i < 20; i++) begin
            if ($urandom_range(0, 3) == 0) begin
                mode = M_NOISE;
            end else begin
                mode = M_CTRL;
                pattern = 8'($urandom);
            end
            wait_valid(ok);
        end

`ifdef NES_PRESS_EDGE_EN
        poll_pattern(8'h00, 8'h00, "press_clear");
        poll_pattern(8'h02, 8'h02, "b_hold1");
        chk("b_press_first", int'({a_press, b_press}), 1);
        poll_pattern(8'h02, 8'h02, "b_hold2");
        chk("b_press_held2", int'({a_press, b_press}), 0);
        poll_pattern(8'h02, 8'h02, "b_hold3");
        chk("b_press_held3", int'({a_press, b_press}), 0);
        poll_pattern(8'h00, 8'h00, "b_release");
        chk("b_press_release", int'({a_press, b_press}), 0);
        poll_pattern(8'h03, 8'h03, "ab_repress");
        chk("ab_press_again", int'({a_press, b_press}), 3);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout actual=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/nes_controller_reader.md
NES_CONTROLLER_READER -- requirements
Module: nes_controller_reader

Interface
REQ-001 SHALL have parameter HALF_PERIOD, default 300, clk cycles per controller-clock half period (6 us at 50 MHz); legal values are 4 or more.
REQ-002 SHALL have parameter POLL_PERIOD, default 833333, clk cycles between poll starts (60 Hz at 50 MHz); legal values are 20*HALF_PERIOD or more.
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port start, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port nes_data, input, 1 bit: controller serial data, active-low, asynchronous to clk.
REQ-006 SHALL have port nes_latch, output, 1 bit: controller latch strobe.
REQ-007 SHALL have port nes_pulse, output, 1 bit: controller shift clock.
REQ-008 SHALL have ports a, b, select_btn, start_btn, up, down, left, right, each an output of 1 bit: registered button state, active-high, ready to drive the player inputs directly.
REQ-009 SHALL have port valid, output, 1 bit: one-cycle pulse when the button outputs update.

Function
REQ-010 SHALL pass nes_data through a 2-flop synchronizer; all sampling SHALL use the synchronized value, inverted.
REQ-011 SHALL run a poll counter from 0 to POLL_PERIOD-1 and then wrap to 0; a poll starts when the counter reaches POLL_PERIOD-1 and the FSM is in IDLE.
REQ-012 SHALL implement FSM states IDLE, LATCH, WAIT0, PULSE_HI, PULSE_LO and DONE.
REQ-013 LATCH SHALL drive nes_latch=1 for exactly 2*HALF_PERIOD cycles and then go to WAIT0.
REQ-014 WAIT0 SHALL hold nes_latch=0 and nes_pulse=0 for HALF_PERIOD cycles, sample bit 0 on the last cycle, and then go to PULSE_HI.
REQ-015 PULSE_HI SHALL drive nes_pulse=1 for HALF_PERIOD cycles; PULSE_LO SHALL drive nes_pulse=0 for HALF_PERIOD cycles and sample on its last cycle.
REQ-016 The PULSE_HI/PULSE_LO pair SHALL repeat 7 times to capture bits 1..7, and the FSM SHALL go to DONE after bit 7.
REQ-017 Bit order SHALL be 0=a, 1=b, 2=select_btn, 3=start_btn, 4=up, 5=down, 6=left, 7=right.
REQ-018 DONE SHALL last one cycle: all 8 button outputs update together from the shift register, valid=1, and the FSM then goes to IDLE.
REQ-019 Button outputs SHALL never change outside DONE, so a partial read is never visible.
REQ-020 SOCD rule: if left and right are both sampled 1, both SHALL output 0; the same applies to up and down.
REQ-021 A disconnected controller (nes_data held high) SHALL produce all buttons 0, with valid still pulsing once per poll.
REQ-022 A poll tick that arrives outside IDLE SHALL be dropped and SHALL NOT be queued.
REQ-023 Latency SHALL be 20*HALF_PERIOD+1 cycles from the poll tick to valid.

Reset
REQ-024 With start=1 at a clk edge, the block SHALL take these values at that edge: FSM=IDLE, poll counter=0, shift register=0, synchronizer=1, nes_latch=0, nes_pulse=0, all buttons=0, valid=0; with CONFIG enabled, a_press=0, b_press=0 and the previous-state registers=0.
REQ-025 Reset asserted mid-read SHALL abort the read with no valid pulse and no output update; the first poll after release SHALL occur POLL_PERIOD cycles later.

Configuration
REQ-026 Macro NES_PRESS_EDGE_EN: when it is defined, the block SHALL add output ports a_press and b_press (1 bit each); each pulses for one cycle, coincident with valid, when the new a (or b) is 1 and the previous a (or b) was 0 (fireball trigger).
REQ-027 When NES_PRESS_EDGE_EN is undefined, a_press and b_press and their previous-state registers SHALL be absent, and all other behaviour SHALL be identical.

Verification (HALF_PERIOD=4, POLL_PERIOD=100)
REQ-028 Release reset, nes_data=1 -> nes_latch high on cycles 99..106; valid at cycle 180; all buttons 0.
REQ-029 Model returns bit pattern a=1, right=1 (nes_data low on bits 0 and 7) -> a=1, right=1, others 0; valid exactly once per 100 cycles.
REQ-030 Model presses left and right together -> left=0, right=0; next poll with only left pressed -> left=1.
REQ-031 Assert start for 1 cycle during the PULSE_HI of bit 3 -> nes_latch=0, nes_pulse=0 and outputs 0 at the next edge; no valid until 100 cycles after release.
REQ-032 With NES_PRESS_EDGE_EN defined, b held over 3 polls -> b_press pulses only on the first poll; b released then re-pressed -> b_press pulses again.
